// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: line geometry, the
// arbiter state encoding, the requester (owner) encoding and the tie-break
// helper used when both caches ask in the same cycle.
package mem_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_LINE_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WB_WAIT  = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    // Choose the side to grant. A lone requester always wins. On a tie the
    // D-side wins unless alternation is enabled and D won the previous tie.
    function automatic owner_t pick_owner(
        input logic   i_req,
        input logic   d_req,
        input owner_t last_tie,
        input logic   rr_en
    );
        owner_t win;
        win = OWNER_D;
        if (i_req && d_req) begin
            if (rr_en && (last_tie == OWNER_D)) begin
                win = OWNER_I;
            end else begin
                win = OWNER_D;
            end
        end else if (i_req) begin
            win = OWNER_I;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole master of the unified line memory. Arbitrates I-cache
// fills and D-cache (optional write-back, then fill) requests, one 4-cycle
// memory access at a time, and returns the line with a one-cycle done pulse.
// Build option: ARB_RR_EN -- when defined, simultaneous requests alternate
// between the two sides (D wins the first tie); otherwise D always wins ties.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LINE_W = MEM_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_dirty,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [LINE_W-1:0] d_wb_data,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rd_data,
    input  logic              mem_rdy
);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    owner_t            owner_reg;
    logic              dirty_reg;
    logic [ADDR_W-1:0] fill_addr_reg;
    logic [ADDR_W-1:0] wb_addr_reg;
    logic [LINE_W-1:0] wb_data_reg;
    logic [LINE_W-1:0] i_rdata_reg;
    logic [LINE_W-1:0] d_rdata_reg;
    logic              mem_rdy_q_reg;

    owner_t            grant_owner;
    logic              grant_en;
    logic              grant_dirty;
    logic [ADDR_W-1:0] grant_fill_addr;
    logic              capture_en;
    owner_t            last_tie;

`ifdef ARB_RR_EN
    localparam logic RR_EN = 1'b1;
    owner_t last_grant_reg;
    assign last_tie = last_grant_reg;
`else
    localparam logic RR_EN = 1'b0;
    assign last_tie = OWNER_I;
`endif

    // Grant decision: only from IDLE, only when memory reported ready last cycle.
    always_comb begin
        grant_owner     = pick_owner(i_req, d_req, last_tie, RR_EN);
        grant_fill_addr = (grant_owner == OWNER_D) ? d_addr : i_addr;
        grant_dirty     = (grant_owner == OWNER_D) && d_dirty;
        grant_en        = !rst && (state_reg == ST_IDLE) && mem_rdy_q_reg
                          && (i_req || d_req);
    end

    // Next-state and capture decode; the only place the live mem_rdy is used.
    always_comb begin
        state_next = state_reg;
        capture_en = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (grant_en) begin
                    state_next = grant_dirty ? ST_WB_WAIT : ST_RD_WAIT;
                end
            end
            ST_WB_WAIT: begin
                if (mem_rdy) begin
                    state_next = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                if (mem_rdy_q_reg) begin
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rdy) begin
                    capture_en = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (rst) begin
            capture_en = 1'b0;
            state_next = ST_IDLE;
        end
    end

    // Memory-side and done outputs. Issue strobes depend only on registered
    // readiness so there is no path from mem_rdy back into mem_re/mem_we.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fill_addr_reg;
        mem_wdata = dirty_reg ? wb_data_reg : '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (grant_en) begin
                    if (grant_dirty) begin
                        mem_we    = 1'b1;
                        mem_addr  = d_wb_addr;
                        mem_wdata = d_wb_data;
                    end else begin
                        mem_re    = 1'b1;
                        mem_addr  = grant_fill_addr;
                        mem_wdata = '0;
                    end
                end
            end
            ST_WB_WAIT: begin
                mem_addr = wb_addr_reg;
            end
            ST_RD_ISSUE: begin
                mem_re = mem_rdy_q_reg && !rst;
            end
            ST_RD_WAIT: begin
                mem_addr = fill_addr_reg;
            end
            ST_RESP: begin
                i_done = !rst && (owner_reg == OWNER_I);
                d_done = !rst && (owner_reg == OWNER_D);
            end
            default: begin
                mem_addr = fill_addr_reg;
            end
        endcase
    end

    // State register and the one-cycle-delayed memory ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            mem_rdy_q_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_rdy_q_reg <= mem_rdy;
        end
    end

    // Access latches: everything the access needs is frozen at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg     <= OWNER_I;
            dirty_reg     <= 1'b0;
            fill_addr_reg <= '0;
            wb_addr_reg   <= '0;
            wb_data_reg   <= '0;
        end else if (grant_en) begin
            owner_reg     <= grant_owner;
            dirty_reg     <= grant_dirty;
            fill_addr_reg <= grant_fill_addr;
            wb_addr_reg   <= d_wb_addr;
            wb_data_reg   <= d_wb_data;
        end
    end

    // Per-side fill data; each side keeps its last line until its next fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else if (capture_en) begin
            if (owner_reg == OWNER_I) begin
                i_rdata_reg <= mem_rd_data;
            end else begin
                d_rdata_reg <= mem_rd_data;
            end
        end
    end

`ifdef ARB_RR_EN
    // Remember who won the most recent contested grant so ties alternate.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= OWNER_I;
        end else if (grant_en && i_req && d_req) begin
            last_grant_reg <= grant_owner;
        end
    end
`endif

    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a line memory model with fixed 4-cycle access,
// a transaction-level reference of the arbiter checked every cycle, directed
// scenarios with literal expectations, then randomized traffic on both sides.
module tb_mem_arbiter;

    localparam int AW = 14;
    localparam int LW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_done;
    logic [LW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          d_dirty = 1'b0;
    logic [AW-1:0] d_wb_addr = '0;
    logic [LW-1:0] d_wb_data = '0;
    logic          d_done;
    logic [LW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rd_data;
    logic          mem_rdy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_dirty(d_dirty),
        .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_line(input int a);
        return {16'hA5A5, 16'(a), 16'h5A5A, 16'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Unified memory model: issue busies it for three cycles, ready on the
    // fourth; ready is combinationally low during an issue cycle.
    logic [63:0] mem     [0:16383];
    logic [63:0] ref_mem [0:16383];
    logic [63:0] mem_rd_q = '0;
    int          busy_cnt = 0;

    assign mem_rdy     = (busy_cnt == 0) && !mem_re && !mem_we;
    assign mem_rd_data = mem_rd_q;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rd_q <= mem[mem_addr];
        if (mem_re || mem_we) busy_cnt <= 2;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Reference arbiter, transaction level: a grant happens whenever the
    // arbiter is free, some side asks and memory was ready last cycle; a
    // clean access completes 4 cycles later, a dirty one 8 cycles later.
    bit          rdy_prev = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_own_d = 1'b0;
    bit          m_dirty = 1'b0;
    bit          last_tie_d = 1'b0;
    bit          prev_issue = 1'b0;
    int          m_t0 = 0;
    logic [13:0] m_fill = '0;
    logic [13:0] m_wb = '0;
    logic [63:0] m_wbdata = '0;
    logic [63:0] m_exp = '0;
    logic [63:0] i_exp = '0;
    logic [63:0] d_exp = '0;
    int          last_re_cyc = 0;
    int          last_we_cyc = 0;
    int          i_done_cyc = 0;
    int          d_done_cyc = 0;
    int          i_done_cnt = 0;

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        bit          e_re, e_we, e_id, e_dd, c_addr, c_wdata, win_d, fin;
        logic [13:0] e_addr;
        logic [63:0] e_wdata;
        int          k, last;
        e_re = 0; e_we = 0; e_id = 0; e_dd = 0; c_addr = 0; c_wdata = 0;
        win_d = 0; fin = 0; e_addr = '0; e_wdata = '0; k = 0; last = 0;
        if (rst) begin
            if (m_busy) begin
                k = cyc - m_t0;
                last = m_dirty ? 8 : 4;
                if (k == last) begin
                    if (m_own_d) d_exp = m_exp; else i_exp = m_exp;
                end
            end
            m_busy = 0;
            last_tie_d = 0;
        end else if (!m_busy) begin
            if (rdy_prev && (i_req || d_req)) begin
                if (i_req && d_req) begin
`ifdef ARB_RR_EN
                    win_d = !last_tie_d;
                    last_tie_d = win_d;
`else
                    win_d = 1'b1;
`endif
                end else begin
                    win_d = d_req;
                end
                m_busy   = 1;
                m_t0     = cyc;
                m_own_d  = win_d;
                m_dirty  = win_d && d_dirty;
                m_fill   = win_d ? d_addr : i_addr;
                m_wb     = d_wb_addr;
                m_wbdata = d_wb_data;
                if (m_dirty) begin
                    ref_mem[m_wb] = m_wbdata;
                    e_we = 1; c_addr = 1; e_addr = m_wb; c_wdata = 1; e_wdata = m_wbdata;
                end else begin
                    e_re = 1; c_addr = 1; e_addr = m_fill;
                end
                m_exp = ref_mem[m_fill];
            end
        end else begin
            k = cyc - m_t0;
            last = m_dirty ? 8 : 4;
            if (m_dirty && k == 4) begin
                e_re = 1; c_addr = 1; e_addr = m_fill;
            end else if (m_dirty && k < 4) begin
                c_addr = 1; e_addr = m_wb; c_wdata = 1; e_wdata = m_wbdata;
            end else if (k < last) begin
                c_addr = 1; e_addr = m_fill;
            end
            if (k == last) begin
                fin = 1;
                if (m_own_d) e_dd = 1; else e_id = 1;
            end
        end

        chk("mem_re", mem_re, e_re);
        chk("mem_we", mem_we, e_we);
        chk("i_done", i_done, e_id);
        chk("d_done", d_done, e_dd);
        if (c_addr) chk("mem_addr", mem_addr, e_addr);
        if (c_wdata) chk("mem_wdata", mem_wdata, e_wdata);
        if (e_id) i_exp = m_exp;
        if (e_dd) d_exp = m_exp;
        chk("i_rdata", i_rdata, i_exp);
        chk("d_rdata", d_rdata, d_exp);
        chk("re_and_we", mem_re && mem_we, 0);
        chk("issue_twice", prev_issue && (mem_re || mem_we), 0);
        chk("issue_busy", (mem_re || mem_we) && (busy_cnt != 0), 0);
        prev_issue = mem_re || mem_we;
        if (rst) begin
            i_exp = '0;
            d_exp = '0;
        end
        if (fin) m_busy = 0;
        rdy_prev = rst ? 1'b0 : mem_rdy;

        if (mem_re) last_re_cyc = cyc;
        if (mem_we) last_we_cyc = cyc;
        if (i_done) begin i_done_cyc = cyc; i_done_cnt++; end
        if (d_done) d_done_cyc = cyc;
    end

    task automatic i_request(input logic [13:0] a);
        int n;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = a;
        n = 0;
        @(negedge clk);
        while (!i_done && n < 100) begin @(negedge clk); n++; end
        chk("i_req_completes", i_done, 1);
        @(posedge clk); #1;
        i_req = 1'b0;
        $display("[TB] I fill %h -> %h at cycle %0d", a, i_rdata, i_done_cyc);
    endtask

    task automatic d_request(input logic [13:0] a, input bit dirty,
                             input logic [13:0] wa, input logic [63:0] wd);
        int n;
        @(posedge clk); #1;
        d_req = 1'b1; d_addr = a; d_dirty = dirty; d_wb_addr = wa; d_wb_data = wd;
        n = 0;
        @(negedge clk);
        while (!d_done && n < 100) begin @(negedge clk); n++; end
        chk("d_req_completes", d_done, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
        $display("[TB] D fill %h dirty=%0d wb %h -> %h at cycle %0d", a, dirty, wa, d_rdata, d_done_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, cnt0, dd;
        for (int a = 0; a < 16384; a++) begin
            mem[a] = init_line(a);
            ref_mem[a] = init_line(a);
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_i_rdata", i_rdata, 64'h0);
        chk("reset_d_rdata", d_rdata, 64'h0);

        // Clean I fill
        i_request(14'h0010);
        chk("t1_latency", i_done_cyc - last_re_cyc, 4);
        chk("t1_data", i_rdata, 64'hA5A5_0010_5A5A_0010);

        // Dirty D: write-back then fill
        d_request(14'h0300, 1'b1, 14'h0200, 64'hDEAD_BEEF_0123_4567);
        chk("t2_re_after_we", last_re_cyc - last_we_cyc, 4);
        chk("t2_done_after_we", d_done_cyc - last_we_cyc, 8);
        chk("t2_data", d_rdata, 64'hA5A5_0300_5A5A_0300);
        chk("t2_mem_written", mem[14'h0200], 64'hDEAD_BEEF_0123_4567);
        i_request(14'h0200);
        chk("t2_readback", i_rdata, 64'hDEAD_BEEF_0123_4567);

        // Simultaneous requests
        fork
            i_request(14'h0020);
            d_request(14'h0030, 1'b0, 14'h0000, 64'h0);
        join
        chk("t3_d_first", d_done_cyc < i_done_cyc, 1);
        chk("t3_i_follows", i_done_cyc - d_done_cyc, 5);
        chk("t3_i_data", i_rdata, 64'hA5A5_0020_5A5A_0020);
        fork
            i_request(14'h0021);
            d_request(14'h0031, 1'b0, 14'h0000, 64'h0);
        join
`ifdef ARB_RR_EN
        chk("t3_second_tie_i_first", i_done_cyc < d_done_cyc, 1);
`else
        chk("t3_second_tie_d_first", d_done_cyc < i_done_cyc, 1);
`endif

        // Reset in the middle of a read
        cnt0 = i_done_cnt;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 14'h0040;
        n = 0;
        @(negedge clk);
        while (!mem_re && n < 20) begin @(negedge clk); n++; end
        chk("t4_first_issue", mem_re, 1);
        t0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b1; i_addr = 14'h0044;
        n = 0;
        @(negedge clk);
        while (!i_done && n < 50) begin @(negedge clk); n++; end
        chk("t4_done_after_reset", i_done, 1);
        @(posedge clk); #1;
        i_req = 1'b0;
        chk("t4_reissue_cycle", last_re_cyc - t0, 4);
        chk("t4_single_done", i_done_cnt - cnt0, 1);
        chk("t4_data", i_rdata, 64'hA5A5_0044_5A5A_0044);
        $display("[TB] reset mid-read: reissue %0d cycles after first issue", last_re_cyc - t0);

        // Back-to-back clean D fills
        d_request(14'h0001, 1'b0, 14'h0000, 64'h0);
        dd = d_done_cyc;
        chk("t5_first_data", d_rdata, 64'hA5A5_0001_5A5A_0001);
        d_request(14'h0002, 1'b0, 14'h0000, 64'h0);
        chk("t5_gap", (last_re_cyc - dd) >= 1, 1);
        chk("t5_second_data", d_rdata, 64'hA5A5_0002_5A5A_0002);

        // Randomized traffic from both sides over a shared address pool
        fork
            begin
                for (int j = 0; j < 30; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    i_request(14'h0100 + 14'($urandom_range(0, 15)));
                end
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    d_request(14'h0100 + 14'($urandom_range(0, 15)),
                              1'($urandom_range(0, 1)),
                              14'h0100 + 14'($urandom_range(0, 15)),
                              {$urandom, $urandom});
                end
            end
        join

        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
